// File: rtl/lsu_pkg.sv
// lsu_pkg: shared opcodes, state encoding and default widths for the load/store sequencer.
package lsu_pkg;
  localparam int XLEN_DEFAULT = 64;
  localparam int RD_W_DEFAULT = 5;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  typedef enum logic [2:0] {IDLE, ADDR, REQ, WAIT, WB} lsu_state_t;
endpackage

// File: rtl/lsu_imm_gen.sv
// lsu_imm_gen: sign-extended I-format (load) or S-format (store) immediate.
module lsu_imm_gen
  import lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);
  logic [11:0] imm12;
  logic        unused_fields;
  assign imm12 = (instr[6:0] == OPC_STORE) ? {instr[31:25], instr[11:7]} : instr[31:20];
  assign imm = {{(XLEN-12){imm12[11]}}, imm12};
  assign unused_fields = ^instr[19:12];
endmodule

// File: rtl/lsu_sequencer.sv
// lsu_sequencer: multi-cycle RV64 ld/sd sequencer driving a req/gnt + rvalid data-memory port.
// Define LSU_MISALIGN_TRAP_EN to trap non-doubleword-aligned addresses instead of issuing them.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int RD_W = RD_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  output logic            misalign
);
  lsu_state_t      state, state_n;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] rs1_q, imm, ea;
  logic            accept, ldst, is_store, trap;

  lsu_imm_gen #(.XLEN(XLEN)) u_imm (.instr(instr_q), .imm(imm));

  assign accept   = (state == IDLE) && instr_valid;
  assign ldst     = (instruction[6:0] == OPC_LOAD) || (instruction[6:0] == OPC_STORE);
  assign is_store = instr_q[6:0] == OPC_STORE;
  assign ea       = rs1_q + imm;
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ea[2:0] != 3'b000;
`else
  assign trap = 1'b0;
`endif

  assign instr_ready = state == IDLE;
  assign mem_req     = state == REQ;
  assign mem_we      = mem_req && is_store;
  assign wb_valid    = (state == WB) && (wb_rd != '0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (instr_valid && ldst) ? ADDR : IDLE;
      ADDR: state_n = trap ? IDLE : REQ;
      REQ:  state_n = mem_gnt ? (is_store ? IDLE : WAIT) : REQ;
      WAIT: state_n = mem_rvalid ? WB : WAIT;
      WB:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Address and store data are registered before REQ so they stay frozen while gnt is withheld.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr_q   <= '0;
      rs1_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
      illegal   <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      if (accept) begin
        instr_q   <= instruction;
        rs1_q     <= rs1_data;
        mem_wdata <= rs2_data;
      end
      if (state == ADDR) mem_addr <= ea;
      if (state == WAIT && mem_rvalid) begin
        wb_rd   <= instr_q[7 +: RD_W];
        wb_data <= mem_rdata;
      end
      illegal  <= accept && !ldst;
      misalign <= (state == ADDR) && trap;
    end
endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer: directed scoreboard bench for lsu_sequencer and lsu_imm_gen.
module tb_lsu_sequencer;
  import lsu_pkg::*;
  localparam int XLEN = 64;
  localparam int RD_W = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic instr_valid = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] instruction = '0;
  logic [XLEN-1:0] rs1_data = '0, rs2_data = '0, mem_rdata = '0;
  logic instr_ready, mem_req, mem_we, wb_valid, illegal, misalign;
  logic [XLEN-1:0] mem_addr, mem_wdata, wb_data;
  logic [RD_W-1:0] wb_rd;
  logic [31:0] imm_instr = '0;
  logic [XLEN-1:0] imm_out;

  always #5 clk = ~clk;

  lsu_sequencer #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal), .misalign(misalign)
  );

  lsu_imm_gen #(.XLEN(XLEN)) u_imm (.instr(imm_instr), .imm(imm_out));

  typedef struct {logic we; logic [63:0] addr; logic [63:0] wdata;} req_t;
  typedef struct {logic [4:0] rd; logic [63:0] data;} wb_t;
  req_t exp_req[$];
  wb_t  exp_wb[$];
  req_t er;
  wb_t  ew;
  int n_chk = 0, n_fail = 0, ill_seen = 0, ill_exp = 0, mis_seen = 0, mis_exp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_req && mem_gnt) begin
      if (exp_req.size() == 0) check("unexpected_mem_req", 64'd1, 64'd0);
      else begin
        er = exp_req.pop_front();
        check("req_addr", mem_addr, er.addr);
        check("req_we", {63'd0, mem_we}, {63'd0, er.we});
        if (er.we) check("req_wdata", mem_wdata, er.wdata);
      end
    end
    if (rst_n && wb_valid) begin
      if (exp_wb.size() == 0) check("unexpected_wb", 64'd1, 64'd0);
      else begin
        ew = exp_wb.pop_front();
        check("wb_rd", {59'd0, wb_rd}, {59'd0, ew.rd});
        check("wb_data", wb_data, ew.data);
      end
    end
    if (illegal) ill_seen++;
    if (misalign) mis_seen++;
  end

  task automatic run_txn(input string tag, input logic [31:0] ins, input logic [63:0] r1,
                         input logic [63:0] r2, input int gdly, input logic [63:0] rdat,
                         input logic exp_we, input logic [63:0] exp_addr, input logic [4:0] exp_rd);
    exp_req.push_back('{exp_we, exp_addr, r2});
    if (!exp_we && exp_rd != 0) exp_wb.push_back('{exp_rd, rdat});
    instr_valid = 1'b1; instruction = ins; rs1_data = r1; rs2_data = r2;
    step();
    instr_valid = 1'b0;
    check({tag, "_ready_busy"}, {63'd0, instr_ready}, 64'd0);
    step();
    check({tag, "_req_latency"}, {63'd0, mem_req}, 64'd1);
    for (int i = 0; i < gdly; i++) begin
      step();
      check({tag, "_req_held"}, {63'd0, mem_req}, 64'd1);
      check({tag, "_addr_held"}, mem_addr, exp_addr);
      check({tag, "_ready_held"}, {63'd0, instr_ready}, 64'd0);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    if (exp_we) check({tag, "_ready_after_store"}, {63'd0, instr_ready}, 64'd1);
    else begin
      check({tag, "_req_drop"}, {63'd0, mem_req}, 64'd0);
      mem_rvalid = 1'b1; mem_rdata = rdat;
      step();
      mem_rvalid = 1'b0; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      check({tag, "_wb_valid"}, {63'd0, wb_valid}, {63'd0, exp_rd != 0});
      step();
      check({tag, "_ready_after_wb"}, {63'd0, instr_ready}, 64'd1);
    end
  endtask

  initial begin
    #2;
    check("rst_ready", {63'd0, instr_ready}, 64'd1);
    check("rst_req_we", {62'd0, mem_req, mem_we}, 64'd0);
    check("rst_addr_wdata", mem_addr | mem_wdata, 64'd0);
    check("rst_wb", {58'd0, wb_valid, wb_rd} | wb_data, 64'd0);
    check("rst_pulses", {62'd0, illegal, misalign}, 64'd0);

    imm_instr = 32'hFE50BC23; #1 check("imm_store_neg", imm_out, 64'hFFFF_FFFF_FFFF_FFF8);
    imm_instr = 32'h00813183; #1 check("imm_load_pos", imm_out, 64'h8);
    imm_instr = 32'h80003003; #1 check("imm_load_min", imm_out, 64'hFFFF_FFFF_FFFF_F800);
    imm_instr = 32'h00000FA3; #1 check("imm_store_31", imm_out, 64'd31);

    step(); step();
    rst_n = 1'b1;
    step();

    run_txn("ld_basic", 32'h00813183, 64'h1000, 64'h0, 0, 64'hDEADBEEF, 1'b0, 64'h1008, 5'd3);
    run_txn("sd_neg", 32'hFE50BC23, 64'h2000, 64'h55, 0, 64'h0, 1'b1, 64'h1FF8, 5'd0);
    run_txn("ld_stall", 32'h0002B383, 64'h3000, 64'h0, 4, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h3000, 5'd7);
    run_txn("sd_stall", 32'hFE50BC23, 64'h4000, 64'hCAFE, 2, 64'h0, 1'b1, 64'h3FF8, 5'd0);

    ill_exp++;
    instr_valid = 1'b1; instruction = 32'h00000033;
    step();
    instr_valid = 1'b0;
    check("ill_pulse", {63'd0, illegal}, 64'd1);
    check("ill_ready", {63'd0, instr_ready}, 64'd1);
    check("ill_no_req", {63'd0, mem_req}, 64'd0);
    step();
    check("ill_pulse_end", {63'd0, illegal}, 64'd0);
    check("ill_no_req2", {63'd0, mem_req}, 64'd0);

    run_txn("ld_x0_wrap", 32'h0100B003, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, 64'h1234, 1'b0, 64'h8, 5'd0);

    exp_req.push_back('{1'b0, 64'h1008, 64'h0});
    instr_valid = 1'b1; instruction = 32'h00813183; rs1_data = 64'h1000; rs2_data = 64'h0;
    step();
    instr_valid = 1'b0;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_req", {63'd0, mem_req}, 64'd0);
    check("arst_ready", {63'd0, instr_ready}, 64'd1);
    check("arst_addr", mem_addr, 64'd0);
    check("arst_wb", {63'd0, wb_valid}, 64'd0);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h7777;
    step();
    mem_rvalid = 1'b0;
    check("late_rvalid_wb", {63'd0, wb_valid}, 64'd0);
    step();
    check("late_rvalid_wb2", {63'd0, wb_valid}, 64'd0);
    check("late_rvalid_data", wb_data, 64'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    mis_exp++;
    instr_valid = 1'b1; instruction = 32'h00413183; rs1_data = 64'h1000;
    step();
    instr_valid = 1'b0;
    step();
    check("mis_pulse", {63'd0, misalign}, 64'd1);
    check("mis_no_req", {63'd0, mem_req}, 64'd0);
    check("mis_ready", {63'd0, instr_ready}, 64'd1);
    step();
    check("mis_pulse_end", {63'd0, misalign}, 64'd0);
    check("mis_no_req2", {63'd0, mem_req}, 64'd0);
`else
    run_txn("ld_unaligned", 32'h00413183, 64'h1000, 64'h0, 0, 64'hABCD, 1'b0, 64'h1004, 5'd3);
`endif

    step(); step();
    check("req_queue_empty", 64'(exp_req.size()), 64'd0);
    check("wb_queue_empty", 64'(exp_wb.size()), 64'd0);
    check("illegal_count", 64'(ill_seen), 64'(ill_exp));
    check("misalign_count", 64'(mis_seen), 64'(mis_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
